// File: rtl/am2930_seq_if.sv
// Host-side command and interrupt handshake bundle for the am2930 sequencer controller.
interface am2930_seq_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic       cmd_ready;
  logic       irq;
  logic [3:0] irq_vec;
  logic       irq_ack;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, irq, irq_vec,
    input  cmd_ready, irq_ack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, irq, irq_vec,
    output cmd_ready, irq_ack
  );
endinterface

// File: rtl/am2930_seq.sv
// Controller driving an am2930 program-address sequencer: arbitrates stall, interrupts and host
// commands, mirrors the am2930 stack depth and flags stack misuse.
module am2930_seq #(
  parameter int DEPTH = 17
) (
  input  logic         cp,
  input  logic         rst,
  am2930_seq_if.slave  host,
  input  logic         stall,
  input  logic         full_,
  input  logic         empty_,
  output logic [4:0]   i,
  output logic         ien_,
  output logic         cc_,
  output logic         re_,
  output logic         oe_,
  output logic         cn,
  output logic         ci,
  output logic [3:0]   d,
  output logic [4:0]   depth,
  output logic         ovf,
  output logic         unf,
  output logic         desync,
  output logic         in_isr
);

  typedef enum logic [1:0] {INIT, RUN, SUSP} state_t;

  localparam logic [4:0] PRST = 5'b00000;
  localparam logic [4:0] FPC  = 5'b00001;
  localparam logic [4:0] JMPD = 5'b10001;
  localparam logic [4:0] JSBD = 5'b10111;
  localparam logic [4:0] RTS  = 5'b11100;
  localparam logic [4:0] CHLD = 5'b11110;
  localparam logic [4:0] PSUS = 5'b11111;
  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

  state_t state_reg;
  logic   irq_eligible;
  logic   cmd_take;
  logic   at_full;
  logic   at_empty;

  // Pins the am2930 never needs toggled by this controller.
  assign ien_ = 1'b0;
  assign re_  = 1'b1;
  assign oe_  = 1'b0;
  assign cn   = 1'b0;

  assign irq_eligible   = (state_reg == RUN) && host.irq && !in_isr;
  assign host.cmd_ready = !stall &&
                          (((state_reg == RUN) && !irq_eligible) ||
                           ((state_reg == SUSP) && (host.cmd_op == 2'b11)));
  assign cmd_take       = host.cmd_valid && host.cmd_ready;
  assign at_full        = (depth == DEPTH_MAX);
  assign at_empty       = (depth == 5'd0);

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT;
      i            <= PRST;
      cc_          <= 1'b1;
      ci           <= 1'b0;
      d            <= 4'b0000;
      depth        <= 5'd0;
      ovf          <= 1'b0;
      unf          <= 1'b0;
      desync       <= 1'b0;
      in_isr       <= 1'b0;
      host.irq_ack <= 1'b0;
    end else begin
      host.irq_ack <= 1'b0;
      cc_          <= 1'b1;
      ci           <= 1'b0;
      d            <= 4'b0000;
      case (state_reg)
        INIT: begin
          i         <= PRST;
          state_reg <= RUN;
        end
        RUN: begin
          if ((!full_ && !at_full) || (!empty_ && !at_empty))
            desync <= 1'b1;
          if (stall) begin
            i <= CHLD;
          end else if (irq_eligible) begin
            // The interrupt is acknowledged even when the stack cannot take it.
            host.irq_ack <= 1'b1;
            if (at_full) begin
              i   <= CHLD;
              ovf <= 1'b1;
            end else begin
              i      <= JSBD;
              d      <= host.irq_vec;
              cc_    <= 1'b0;
              ci     <= 1'b1;
              depth  <= depth + 5'd1;
              in_isr <= 1'b1;
            end
          end else if (cmd_take) begin
            case (host.cmd_op)
              2'b00: begin
                i   <= JMPD;
                d   <= host.cmd_addr;
                cc_ <= 1'b0;
                ci  <= 1'b1;
              end
              2'b01: begin
                if (at_full) begin
                  i   <= CHLD;
                  ovf <= 1'b1;
                end else begin
                  i     <= JSBD;
                  d     <= host.cmd_addr;
                  cc_   <= 1'b0;
                  ci    <= 1'b1;
                  depth <= depth + 5'd1;
                end
              end
              2'b10: begin
                if (at_empty) begin
                  i   <= CHLD;
                  unf <= 1'b1;
                end else begin
                  i      <= RTS;
                  cc_    <= 1'b0;
                  ci     <= 1'b1;
                  depth  <= depth - 5'd1;
                  in_isr <= 1'b0;
                end
              end
              default: begin
                i         <= PSUS;
                state_reg <= SUSP;
              end
            endcase
          end else begin
            i  <= FPC;
            ci <= 1'b1;
          end
        end
        SUSP: begin
          // cmd_ready already restricts acceptance here to an unstalled resume.
          if (cmd_take) begin
            i         <= FPC;
            ci        <= 1'b1;
            state_reg <= RUN;
          end else begin
            i <= PSUS;
          end
        end
        default: begin
          i         <= PRST;
          state_reg <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am2930_seq.sv
// Self-checking bench for am2930_seq: directed scenarios plus randomized traffic checked
// against a stack-queue model of the sequencer rules.
module tb_am2930_seq;
  localparam int D = 17;
  localparam logic [4:0] PRST = 5'b00000, FPC = 5'b00001, JMPD = 5'b10001, JSBD = 5'b10111;
  localparam logic [4:0] RTS = 5'b11100, CHLD = 5'b11110, PSUS = 5'b11111;

  logic cp = 1'b0, rst = 1'b0, stall = 1'b0, full_ = 1'b1, empty_ = 1'b0;
  logic [4:0] i, depth;
  logic [3:0] d;
  logic ien_, cc_, re_, oe_, cn, ci, ovf, unf, desync, in_isr;

  am2930_seq_if bus();

  am2930_seq #(.DEPTH(D)) dut (
    .cp(cp), .rst(rst), .host(bus.slave), .stall(stall), .full_(full_), .empty_(empty_),
    .i(i), .ien_(ien_), .cc_(cc_), .re_(re_), .oe_(oe_), .cn(cn), .ci(ci), .d(d),
    .depth(depth), .ovf(ovf), .unf(unf), .desync(desync), .in_isr(in_isr)
  );

  always #5 cp = ~cp;

  int vectors = 0, miscompares = 0;
  logic [20:0] obs, expv;
  logic obs_ready, exp_ready;

  // Reference model: the am2930 stack as a queue of pushed targets plus mode bits.
  logic [3:0] stk[$];
  bit m_init, m_susp, m_isr, m_ovf, m_unf, m_desync;
  logic [4:0] e_i;
  logic [3:0] e_d;
  logic e_cc, e_ci, e_ack;

  function automatic void model_reset();
    stk.delete();
    m_init = 1; m_susp = 0; m_isr = 0; m_ovf = 0; m_unf = 0; m_desync = 0;
    e_i = PRST; e_d = 4'd0; e_cc = 1; e_ci = 0; e_ack = 0;
  endfunction

  function automatic bit m_ready(input logic st, input logic iq, input logic [1:0] op);
    if (m_init) return 1'b0;
    if (m_susp) return !st && (op == 2'b11);
    return !st && !(iq && !m_isr);
  endfunction

  function automatic void model_edge(input logic v, input logic [1:0] op, input logic [3:0] a,
                                     input logic iq, input logic [3:0] iv, input logic st,
                                     input logic f_, input logic em_);
    e_ack = 0; e_cc = 1; e_ci = 0; e_d = 4'd0;
    if (m_init) begin
      e_i = PRST; m_init = 0;
      return;
    end
    if (m_susp) begin
      if (v && op == 2'b11 && !st) begin m_susp = 0; e_i = FPC; e_ci = 1; end
      else e_i = PSUS;
      return;
    end
    if ((!f_ && stk.size() < D) || (!em_ && stk.size() != 0)) m_desync = 1;
    if (st) e_i = CHLD;
    else if (iq && !m_isr) begin
      e_ack = 1;
      if (stk.size() == D) begin e_i = CHLD; m_ovf = 1; end
      else begin stk.push_back(iv); m_isr = 1; e_i = JSBD; e_d = iv; e_cc = 0; e_ci = 1; end
    end else if (v) begin
      case (op)
        2'b00: begin e_i = JMPD; e_d = a; e_cc = 0; e_ci = 1; end
        2'b01: if (stk.size() == D) begin e_i = CHLD; m_ovf = 1; end
               else begin stk.push_back(a); e_i = JSBD; e_d = a; e_cc = 0; e_ci = 1; end
        2'b10: if (stk.size() == 0) begin e_i = CHLD; m_unf = 1; end
               else begin void'(stk.pop_back()); m_isr = 0; e_i = RTS; e_cc = 0; e_ci = 1; end
        default: begin e_i = PSUS; m_susp = 1; end
      endcase
    end else begin
      e_i = FPC; e_ci = 1;
    end
  endfunction

  // Drives one cycle of stimulus from a falling edge; leaves the bench at the next falling edge.
  task automatic apply(input logic v, input logic [1:0] op, input logic [3:0] a, input logic iq,
                       input logic [3:0] iv, input logic st, input logic bad);
    bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_addr = a;
    bus.irq = iq; bus.irq_vec = iv; stall = st;
    full_  = bad ? 1'b0 : !(stk.size() == D);
    empty_ = !(stk.size() == 0);
    #1;
    obs_ready = bus.cmd_ready;
    exp_ready = m_ready(st, iq, op);
    model_edge(v, op, a, iq, iv, st, full_, empty_);
    @(posedge cp);
    #1;
    obs  = {i, cc_, ci, d, depth, ovf, unf, desync, in_isr, bus.irq_ack};
    expv = {e_i, e_cc, e_ci, e_d, 5'(stk.size()), m_ovf, m_unf, m_desync, m_isr, e_ack};
    @(negedge cp);
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 0; bus.irq = 0; stall = 0;
    #2 rst = 1;
    model_reset();
    @(negedge cp);
    rst = 0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.irq = 0; bus.irq_vec = 0;
    #1 rst = 1;
    model_reset();
    #1;
    vectors++;
    if ({i, cc_, ci, d, depth, ovf, unf, desync, in_isr, bus.irq_ack, bus.cmd_ready}
        !== {PRST, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got i=%b cc_=%b ci=%b d=%b depth=%0d flags=%b ack=%b rdy=%b, expected PRST cc_=1 rest 0",
               i, cc_, ci, d, depth, {ovf, unf, desync, in_isr}, bus.irq_ack, bus.cmd_ready);
    end
    vectors++;
    if ({ien_, re_, oe_, cn} !== 4'b0100) begin
      miscompares++;
      $display("FAIL static_pins: got ien_,re_,oe_,cn=%b expected 0100", {ien_, re_, oe_, cn});
    end
    @(negedge cp);
    rst = 0;
    idle(1);
    vectors++;
    if ({i, ci, obs_ready} !== {PRST, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL init_cycle: got i=%b ci=%b rdy=%b expected i=00000 ci=0 rdy=0", i, ci, obs_ready);
    end
    for (int k = 0; k < 2; k++) begin
      idle(1);
      vectors++;
      if ({i, ci, depth, obs_ready} !== {FPC, 1'b1, 5'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL idle_fetch %0d: got i=%b ci=%b depth=%0d rdy=%b expected 00001 1 0 1", k, i, ci, depth, obs_ready);
      end
    end
  endtask

  task automatic test_call_return();
    apply(1'b1, 2'b01, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({i, d, cc_, depth} !== {JSBD, 4'b0101, 1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL call: got i=%b d=%b cc_=%b depth=%0d expected 10111 0101 0 1", i, d, cc_, depth);
    end
    apply(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({i, cc_, depth, ovf, unf, desync} !== {RTS, 1'b0, 5'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL return: got i=%b cc_=%b depth=%0d flags=%b expected 11100 0 0 000", i, cc_, depth, {ovf, unf, desync});
    end
  endtask

  task automatic test_irq_priority();
    apply(1'b1, 2'b00, 4'b0011, 1'b1, 4'b1100, 1'b0, 1'b0);
    vectors++;
    if ({obs_ready, i, d, bus.irq_ack, in_isr, depth} !== {1'b0, JSBD, 4'b1100, 1'b1, 1'b1, 5'd1}) begin
      miscompares++;
      $display("FAIL irq_accept: got rdy=%b i=%b d=%b ack=%b isr=%b depth=%0d expected 0 10111 1100 1 1 1",
               obs_ready, i, d, bus.irq_ack, in_isr, depth);
    end
    apply(1'b1, 2'b00, 4'b0011, 1'b1, 4'b1100, 1'b0, 1'b0);
    vectors++;
    if ({obs_ready, i, d, bus.irq_ack} !== {1'b1, JMPD, 4'b0011, 1'b0}) begin
      miscompares++;
      $display("FAIL held_cmd: got rdy=%b i=%b d=%b ack=%b expected 1 10001 0011 0", obs_ready, i, d, bus.irq_ack);
    end
    apply(1'b0, 2'b00, 4'd0, 1'b1, 4'b0110, 1'b0, 1'b0);
    vectors++;
    if ({i, bus.irq_ack, depth} !== {FPC, 1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL irq_in_isr: got i=%b ack=%b depth=%0d expected 00001 0 1", i, bus.irq_ack, depth);
    end
    apply(1'b1, 2'b10, 4'd0, 1'b1, 4'b0110, 1'b0, 1'b0);
    vectors++;
    if ({i, in_isr, depth} !== {RTS, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL isr_return: got i=%b isr=%b depth=%0d expected 11100 0 0", i, in_isr, depth);
    end
    apply(1'b0, 2'b00, 4'd0, 1'b1, 4'b0110, 1'b0, 1'b0);
    vectors++;
    if ({i, d, bus.irq_ack} !== {JSBD, 4'b0110, 1'b1}) begin
      miscompares++;
      $display("FAIL irq_again: got i=%b d=%b ack=%b expected 10111 0110 1", i, d, bus.irq_ack);
    end
    apply(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= D; k++) begin
      apply(1'b1, 2'b01, 4'(k), 1'b0, 4'd0, 1'b0, 1'b0);
      vectors++;
      if ({i, depth} !== {JSBD, 5'(k)}) begin
        miscompares++;
        $display("FAIL fill %0d: got i=%b depth=%0d expected 10111 %0d", k, i, depth, k);
      end
    end
    apply(1'b1, 2'b01, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({i, ovf, depth} !== {CHLD, 1'b1, 5'd17}) begin
      miscompares++;
      $display("FAIL ovf_call: got i=%b ovf=%b depth=%0d expected 11110 1 17", i, ovf, depth);
    end
    apply(1'b0, 2'b00, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0);
    vectors++;
    if ({i, bus.irq_ack, in_isr, depth} !== {CHLD, 1'b1, 1'b0, 5'd17}) begin
      miscompares++;
      $display("FAIL ovf_irq: got i=%b ack=%b isr=%b depth=%0d expected 11110 1 0 17", i, bus.irq_ack, in_isr, depth);
    end
    repeat (D) apply(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({depth, ovf, desync} !== {5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL drain: got depth=%0d ovf=%b desync=%b expected 0 1 0", depth, ovf, desync);
    end
  endtask

  task automatic test_underflow_stall();
    apply(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({i, unf, depth} !== {CHLD, 1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL unf_return: got i=%b unf=%b depth=%0d expected 11110 1 0", i, unf, depth);
    end
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 2'b01, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
      vectors++;
      if ({obs_ready, i, ci, depth} !== {1'b0, CHLD, 1'b0, 5'd0}) begin
        miscompares++;
        $display("FAIL stall %0d: got rdy=%b i=%b ci=%b depth=%0d expected 0 11110 0 0", k, obs_ready, i, ci, depth);
      end
    end
    apply(1'b1, 2'b01, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({obs_ready, i, d, depth} !== {1'b1, JSBD, 4'd9, 5'd1}) begin
      miscompares++;
      $display("FAIL unstall: got rdy=%b i=%b d=%b depth=%0d expected 1 10111 1001 1", obs_ready, i, d, depth);
    end
    apply(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_suspend_resume();
    apply(1'b1, 2'b11, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if (i !== PSUS) begin
      miscompares++;
      $display("FAIL suspend: got i=%b expected 11111", i);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 2'($urandom_range(0, 2)), 4'd5, 1'b1, 4'd3, 1'b0, 1'b0);
      vectors++;
      if ({obs_ready, i, bus.irq_ack} !== {1'b0, PSUS, 1'b0}) begin
        miscompares++;
        $display("FAIL susp_hold %0d: got rdy=%b i=%b ack=%b expected 0 11111 0", k, obs_ready, i, bus.irq_ack);
      end
    end
    apply(1'b1, 2'b11, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    vectors++;
    if ({obs_ready, i, ci} !== {1'b1, FPC, 1'b1}) begin
      miscompares++;
      $display("FAIL resume: got rdy=%b i=%b ci=%b expected 1 00001 1", obs_ready, i, ci);
    end
    apply(1'b1, 2'b11, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    bus.cmd_valid = 1; bus.cmd_op = 2'b11;
    #2 rst = 1;
    #1;
    vectors++;
    if ({i, bus.cmd_ready, ovf, unf, depth} !== {PRST, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL susp_reset: got i=%b rdy=%b ovf=%b unf=%b depth=%0d expected 00000 0 0 0 0",
               i, bus.cmd_ready, ovf, unf, depth);
    end
    model_reset();
    @(negedge cp);
    bus.cmd_valid = 0;
    rst = 0;
  endtask

  task automatic test_desync();
    apply(1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    vectors++;
    if ({i, desync} !== {PRST, 1'b0}) begin
      miscompares++;
      $display("FAIL desync_init: got i=%b desync=%b expected 00000 0", i, desync);
    end
    apply(1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    vectors++;
    if (desync !== 1'b1) begin
      miscompares++;
      $display("FAIL desync_set: got desync=%b expected 1", desync);
    end
    idle(2);
    vectors++;
    if (desync !== 1'b1) begin
      miscompares++;
      $display("FAIL desync_sticky: got desync=%b expected 1", desync);
    end
  endtask

  task automatic test_random();
    logic v, iq, st, bad;
    logic [1:0] op;
    logic [3:0] a, iv;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      v   = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      a   = 4'($urandom);
      iq  = ($urandom_range(0, 7) == 0);
      iv  = 4'($urandom);
      st  = ($urandom_range(0, 9) == 0);
      bad = ($urandom_range(0, 299) == 0);
      // Bias toward calls early on so the stack reaches its limit.
      if (n < 300 && v && op == 2'b10) op = 2'b01;
      apply(v, op, a, iq, iv, st, bad);
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rnd_ready cycle %0d: got %b expected %b", n, obs_ready, exp_ready);
      end
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL rnd_out cycle %0d: got %b expected %b (i,cc_,ci,d,depth,ovf,unf,desync,isr,ack)", n, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_irq_priority();
    test_overflow();
    test_underflow_stall();
    test_suspend_resume();
    test_desync();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
